// File: rtl/chien_search.sv
// rtl/chien_search.sv - Chien search over GF(2^m), m in {6,8,10}; optional macro CHIEN_EARLY_STOP_EN
module chien_search #(
  parameter int T_MAX = 4,
  parameter int M_MAX = 10
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [3:0]                 m,
  input  logic                       bm_failure,
  input  logic [3:0]                 degree,
  input  logic [(T_MAX+1)*M_MAX-1:0] sigma,
  output logic                       busy,
  output logic                       err_valid,
  output logic [M_MAX-1:0]           err_pos,
  output logic [3:0]                 num_err,
  output logic                       done,
  output logic                       failure
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_FIN} state_t;

  state_t           r_state, w_state_nxt;
  logic [M_MAX-1:0] r_reg [T_MAX+1];
  logic [3:0]       r_m;
  logic [3:0]       r_degree;
  logic [M_MAX-1:0] r_k;
  logic [3:0]       r_num;
  logic             r_fin_fail;
  logic             r_busy, r_err_valid, r_done, r_failure;
  logic [M_MAX-1:0] r_err_pos;

  logic [M_MAX-1:0] w_sum, w_n, w_in_mask;
  logic             w_root, w_last, w_early, w_m_ok;
  logic [3:0]       w_num_next;

  // Low m bits set; equals n = 2^m-1 as well as the coefficient mask
  function automatic logic [M_MAX-1:0] field_mask(input logic [3:0] fm);
    logic [M_MAX-1:0] v;
    v = '0;
    for (int b = 0; b < M_MAX; b++)
      if (b < int'(fm)) v[b] = 1'b1;
    return v;
  endfunction

  // One shift/reduce step: multiply by alpha under the selected primitive polynomial
  function automatic logic [M_MAX-1:0] mul_alpha(input logic [M_MAX-1:0] x, input logic [3:0] fm);
    logic [M_MAX-1:0] y;
    logic [M_MAX-1:0] poly;
    logic             msb;
    y = {x[M_MAX-2:0], 1'b0} & field_mask(fm);
    case (fm)
      4'd6:    begin msb = x[5]; poly = M_MAX'(6'h03);  end
      4'd8:    begin msb = x[7]; poly = M_MAX'(8'h1D);  end
      4'd10:   begin msb = x[9]; poly = M_MAX'(10'h009); end
      default: begin msb = 1'b0; poly = '0;             end
    endcase
    if (msb) y = y ^ poly;
    return y;
  endfunction

  // Constant multiply by alpha^j as a chain of j single-step networks
  function automatic logic [M_MAX-1:0] mul_alpha_pow(input logic [M_MAX-1:0] x, input int j,
                                                     input logic [3:0] fm);
    logic [M_MAX-1:0] y;
    y = x;
    for (int i = 0; i < T_MAX; i++)
      if (i < j) y = mul_alpha(y, fm);
    return y;
  endfunction

  // Evaluate sigma at the current candidate and derive termination conditions
  always_comb begin
    w_in_mask = field_mask(m);
    w_m_ok    = (m == 4'd6) || (m == 4'd8) || (m == 4'd10);
    w_n       = field_mask(r_m);
    w_sum     = '0;
    for (int j = 0; j <= T_MAX; j++) w_sum = w_sum ^ r_reg[j];
    w_root     = (w_sum == '0);
    w_last     = (r_k == w_n);
    w_num_next = r_num;
    if (w_root && (r_num != 4'd15)) w_num_next = r_num + 4'd1;
`ifdef CHIEN_EARLY_STOP_EN
    w_early = w_root && (w_num_next == r_degree);
`else
    w_early = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (bm_failure || !w_m_ok) w_state_nxt = S_FIN;
`ifdef CHIEN_EARLY_STOP_EN
          else if (degree == 4'd0)   w_state_nxt = S_FIN;
`endif
          else                       w_state_nxt = S_EVAL;
        end
      end
      S_EVAL:  if (w_last || w_early) w_state_nxt = S_IDLE;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: load scaled coefficients, step the evaluator, report roots and verdict
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j <= T_MAX; j++) r_reg[j] <= '0;
      r_m         <= '0;
      r_degree    <= '0;
      r_k         <= '0;
      r_num       <= '0;
      r_fin_fail  <= 1'b0;
      r_busy      <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_pos   <= '0;
      r_done      <= 1'b0;
      r_failure   <= 1'b0;
    end else begin
      r_err_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int j = 0; j <= T_MAX; j++)
              r_reg[j] <= mul_alpha_pow(sigma[j*M_MAX +: M_MAX] & w_in_mask, j, m);
            r_m        <= m;
            r_degree   <= degree;
            r_k        <= M_MAX'(1);
            r_num      <= '0;
            r_failure  <= 1'b0;
            r_fin_fail <= bm_failure || !w_m_ok;
            r_busy     <= 1'b1;
          end
        end
        S_EVAL: begin
          for (int j = 0; j <= T_MAX; j++)
            r_reg[j] <= mul_alpha_pow(r_reg[j], j, r_m);
          r_k   <= r_k + M_MAX'(1);
          r_num <= w_num_next;
          if (w_root) begin
            r_err_valid <= 1'b1;
            r_err_pos   <= w_n - r_k;
          end
          if (w_last || w_early) begin
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_failure <= !w_early && (w_num_next != r_degree);
          end
        end
        S_FIN: begin
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_num     <= '0;
          r_failure <= r_fin_fail;
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign err_valid = r_err_valid;
  assign err_pos   = r_err_pos;
  assign num_err   = r_num;
  assign done      = r_done;
  assign failure   = r_failure;

endmodule

// File: tb/tb_chien_search.sv
// tb/tb_chien_search.sv - directed-vector bench for chien_search
module tb_chien_search;

  localparam int T_MAX = 4;
  localparam int M_MAX = 10;

  logic                       clk;
  logic                       rstn;
  logic                       start;
  logic [3:0]                 m;
  logic                       bm_failure;
  logic [3:0]                 degree;
  logic [(T_MAX+1)*M_MAX-1:0] sigma;
  logic                       busy, err_valid, done, failure;
  logic [M_MAX-1:0]           err_pos;
  logic [3:0]                 num_err;

  int n_checks = 0;
  int n_errors = 0;

  int got_roots, got_done_k, got_num, got_fail, got_busy0, got_busy_done;
  int root_k [4];
  int root_pos [4];

  chien_search #(.T_MAX(T_MAX), .M_MAX(M_MAX)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .m          (m),
    .bm_failure (bm_failure),
    .degree     (degree),
    .sigma      (sigma),
    .busy       (busy),
    .err_valid  (err_valid),
    .err_pos    (err_pos),
    .num_err    (num_err),
    .done       (done),
    .failure    (failure)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Start one search at a negedge and log roots and completion by edge index k
  task automatic run(input logic [3:0] tm, input logic tbf, input logic [3:0] tdeg,
                     input logic [(T_MAX+1)*M_MAX-1:0] tsig, input int pulse_at);
    got_roots = 0; got_done_k = -1; got_num = -1; got_fail = -1; got_busy_done = -1;
    for (int i = 0; i < 4; i++) begin root_k[i] = -1; root_pos[i] = -1; end
    m = tm; bm_failure = tbf; degree = tdeg; sigma = tsig; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_busy0 = int'(busy);
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk);
      start = (k == pulse_at);
      if (err_valid) begin
        if (got_roots < 4) begin
          root_k[got_roots]   = k;
          root_pos[got_roots] = int'(err_pos);
        end
        got_roots++;
      end
      if (done) begin
        got_done_k    = k;
        got_num       = int'(num_err);
        got_fail      = int'(failure);
        got_busy_done = int'(busy);
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_two_roots(input string tag);
    check({tag, "_roots"}, got_roots, 2);
    check({tag, "_k0"}, root_k[0], 62);
    check({tag, "_pos0"}, root_pos[0], 1);
    check({tag, "_k1"}, root_k[1], 63);
    check({tag, "_pos1"}, root_pos[1], 0);
    check({tag, "_done_k"}, got_done_k, 63);
    check({tag, "_num"}, got_num, 2);
    check({tag, "_fail"}, got_fail, 0);
  endtask

  localparam logic [49:0] SIG_T1  = {10'h000, 10'h000, 10'h000, 10'h020, 10'h001};
  localparam logic [49:0] SIG_T2  = {10'h000, 10'h000, 10'h002, 10'h003, 10'h001};
  localparam logic [49:0] SIG_HI  = {10'h000, 10'h000, 10'h000, 10'h3E0, 10'h041};
  localparam logic [49:0] SIG_ONE = {10'h000, 10'h000, 10'h000, 10'h000, 10'h001};

  initial begin
    rstn = 1'b0; start = 1'b0; m = 4'd6; bm_failure = 1'b0; degree = 4'd0; sigma = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_err_pos", err_pos, 0);
    check("rst_num_err", num_err, 0);
    check("rst_done", done, 0);
    check("rst_failure", failure, 0);
    rstn = 1'b1;
    @(negedge clk);

    // single root at position 5; stray start while busy
    run(4'd6, 1'b0, 4'd1, SIG_T1, 20);
    check("t1_busy0", got_busy0, 1);
    check("t1_roots", got_roots, 1);
    check("t1_k", root_k[0], 58);
    check("t1_pos", root_pos[0], 5);
`ifdef CHIEN_EARLY_STOP_EN
    check("t1_done_k", got_done_k, 58);
`else
    check("t1_done_k", got_done_k, 63);
`endif
    check("t1_num", got_num, 1);
    check("t1_fail", got_fail, 0);
    check("t1_busy_done", got_busy_done, 0);

    // two roots, last coincides with done; start accepted while done=1
    run(4'd6, 1'b0, 4'd2, SIG_T2, 0);
    check_two_roots("t2");

    // degree mismatch; coefficient bits at m and above must be ignored
    run(4'd6, 1'b0, 4'd2, SIG_HI, 0);
    check("t3_roots", got_roots, 1);
    check("t3_k", root_k[0], 58);
    check("t3_pos", root_pos[0], 5);
    check("t3_done_k", got_done_k, 63);
    check("t3_num", got_num, 1);
    check("t3_fail", got_fail, 1);

    run(4'd6, 1'b1, 4'd1, SIG_T1, 0);
    check("bmf_roots", got_roots, 0);
    check("bmf_done_k", got_done_k, 1);
    check("bmf_num", got_num, 0);
    check("bmf_fail", got_fail, 1);

    run(4'd7, 1'b0, 4'd1, SIG_T1, 0);
    check("m7_roots", got_roots, 0);
    check("m7_done_k", got_done_k, 1);
    check("m7_num", got_num, 0);
    check("m7_fail", got_fail, 1);

    run(4'd10, 1'b0, 4'd0, SIG_ONE, 0);
    check("m10_roots", got_roots, 0);
`ifdef CHIEN_EARLY_STOP_EN
    check("m10_done_k", got_done_k, 1);
`else
    check("m10_done_k", got_done_k, 1023);
`endif
    check("m10_num", got_num, 0);
    check("m10_fail", got_fail, 0);

    // asynchronous reset in the middle of a search
    m = 4'd6; bm_failure = 1'b0; degree = 4'd2; sigma = SIG_T2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    check("mid_busy", busy, 1);
    #4;
    rstn = 1'b0;
    #0.5;
    check("ar_busy", busy, 0);
    check("ar_err_valid", err_valid, 0);
    check("ar_err_pos", err_pos, 0);
    check("ar_num_err", num_err, 0);
    check("ar_done", done, 0);
    check("ar_failure", failure, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run(4'd6, 1'b0, 4'd2, SIG_T2, 5);
    check_two_roots("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
